// File: rtl/clock_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// clock_reset_sequencer_pkg
// Shared definitions for the DCM bring-up / system reset sequencer:
//   - seq_state_t   : state encodings (also driven onto the STATE debug port)
//   - seq_out_t     : the group of control outputs decoded from a state
//   - decode_outputs: state -> control output decode
//   - sat_inc8      : saturating increment used for the lock-loss counter
// ---------------------------------------------------------------------------
package clock_reset_sequencer_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;
    localparam int LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_DCM = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic dcm_rst;
        logic sys_rst;
        logic ready;
        logic fault;
    } seq_out_t;

    // Unknown encodings decode like RESET_DCM so the outputs stay safe
    // (everything held in reset) while the FSM recovers.
    function automatic seq_out_t decode_outputs(input seq_state_t st);
        seq_out_t o;
        case (st)
            ST_RESET_DCM: o = '{dcm_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_WAIT_LOCK: o = '{dcm_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_SETTLE:    o = '{dcm_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_RUN:       o = '{dcm_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fault: 1'b0};
            ST_FAULT:     o = '{dcm_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b1};
            default:      o = '{dcm_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

    function automatic logic [LOSS_W-1:0] sat_inc8(input logic [LOSS_W-1:0] v);
        logic [LOSS_W-1:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_reset_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic single-bit two-flop synchroniser with synchronous clear. Intended
// for any slow asynchronous status input (DCM lock, PLL status, ...).
// Ports:
//   i_clk : destination clock
//   i_clr : synchronous active-high clear, forces both flops to 0
//   i_d   : asynchronous input
//   o_q   : synchronised output, two destination-clock cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clock_reset_sequencer.sv
// ---------------------------------------------------------------------------
// clock_reset_sequencer
// Brings up the board DCMs and releases the downstream system reset. Each
// attempt pulses DCM_RST, waits (bounded) for the synchronised lock, then
// holds SYS_RST until lock has been continuously present for a settle
// window. Lock loss in RUN or a software request restarts the sequence;
// repeated lock timeouts end in a terminal FAULT state. Runs from the
// free-running BOARD_CLOCK only.
// Ports:
//   BOARD_CLOCK : free-running sequencer clock
//   RST         : synchronous active-high reset
//   LOCKED_IN   : combined DCM lock, asynchronous to BOARD_CLOCK
//   RESYNC_REQ  : single-cycle re-sequence request, acted on only in RUN
//   DCM_RST     : reset to both DCMs
//   SYS_RST     : downstream synchronous reset, active-high
//   READY       : high only in RUN
//   FAULT       : high only in FAULT
//   RETRY_COUNT : failed lock attempts in the current bring-up
//   LOSS_COUNT  : lock losses seen in RUN since RST, saturating at 255
//   STATE       : current state encoding for debug
// ---------------------------------------------------------------------------
module clock_reset_sequencer
    import clock_reset_sequencer_pkg::*;
#(
    parameter int DCM_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 24
) (
    input  logic               BOARD_CLOCK,
    input  logic               RST,
    input  logic               LOCKED_IN,
    input  logic               RESYNC_REQ,
    output logic               DCM_RST,
    output logic               SYS_RST,
    output logic               READY,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_COUNT,
    output logic [LOSS_W-1:0]  LOSS_COUNT,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [CNT_W-1:0]   DCM_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               w_lk;
    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [LOSS_W-1:0]  r_loss;
    logic [LOSS_W-1:0]  w_loss_nxt;
    seq_out_t           r_out;

    sync_2ff u_lock_sync (
        .i_clk (BOARD_CLOCK),
        .i_clr (RST),
        .i_d   (LOCKED_IN),
        .o_q   (w_lk)
    );

    // Next-state, counter, retry and loss-count logic. One shared counter is
    // reused by each timed state and is cleared on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            ST_RESET_DCM: begin
                if (r_cnt == DCM_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout cycle wins.
                if (w_lk) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == LOCK_LAST) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_RESET_DCM;
                        w_retry_nxt = r_retry + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_SETTLE: begin
                // A lock glitch restarts the wait but is not a failed attempt.
                if (!w_lk) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                    w_retry_nxt = {RETRY_W{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = CNT_ZERO;
                // Lock loss takes priority so a coincident request is still counted.
                if (!w_lk) begin
                    w_state_nxt = ST_RESET_DCM;
                    w_loss_nxt  = sat_inc8(r_loss);
                end else if (RESYNC_REQ) begin
                    w_state_nxt = ST_RESET_DCM;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
                w_cnt_nxt   = CNT_ZERO;
            end
            default: begin
                w_state_nxt = ST_RESET_DCM;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counters and control outputs; outputs decode the next state so
    // they change on the same edge as the state they belong to.
    always_ff @(posedge BOARD_CLOCK) begin
        if (RST) begin
            r_state <= ST_RESET_DCM;
            r_cnt   <= CNT_ZERO;
            r_retry <= {RETRY_W{1'b0}};
            r_loss  <= {LOSS_W{1'b0}};
            r_out   <= decode_outputs(ST_RESET_DCM);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            r_loss  <= w_loss_nxt;
            r_out   <= decode_outputs(w_state_nxt);
        end
    end

    assign DCM_RST     = r_out.dcm_rst;
    assign SYS_RST     = r_out.sys_rst;
    assign READY       = r_out.ready;
    assign FAULT       = r_out.fault;
    assign RETRY_COUNT = r_retry;
    assign LOSS_COUNT  = r_loss;
    assign STATE       = r_state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clock_reset_sequencer
// Directed bench. The stimulus process pushes each expected output change
// (edge number, state, retry count, loss count) into a queue; a monitor
// watches the DUT outputs every falling edge and, whenever any output
// changes, pops the next expected change and compares it in full.
// ---------------------------------------------------------------------------
module tb_clock_reset_sequencer;

    localparam int DCM_N = 4;
    localparam int TO_N  = 100;
    localparam int SET_N = 16;
    localparam int MR_N  = 2;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_SET  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    localparam logic [16:0] RESET_TUPLE = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       resync = 1'b0;
    logic       dcm_rst, sys_rst, ready, fault;
    logic [1:0] retry;
    logic [7:0] loss;
    logic [2:0] state;

    clock_reset_sequencer #(
        .DCM_RST_CYCLES (DCM_N),
        .LOCK_TIMEOUT   (TO_N),
        .SETTLE_CYCLES  (SET_N),
        .MAX_RETRIES    (MR_N),
        .CNT_W          (24)
    ) dut (
        .BOARD_CLOCK (clk),
        .RST         (rst),
        .LOCKED_IN   (locked),
        .RESYNC_REQ  (resync),
        .DCM_RST     (dcm_rst),
        .SYS_RST     (sys_rst),
        .READY       (ready),
        .FAULT       (fault),
        .RETRY_COUNT (retry),
        .LOSS_COUNT  (loss),
        .STATE       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [2:0] st;
        logic [1:0] rt;
        logic [7:0] ls;
    } ev_t;

    ev_t q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    bit  mon_on = 1'b0;

    // Expected output tuple: control outputs follow from the state alone.
    function automatic logic [16:0] model(input ev_t e);
        logic d, s, r, f;
        d = (e.st == S_RST);
        s = (e.st != S_RUN);
        r = (e.st == S_RUN);
        f = (e.st == S_FLT);
        return {e.st, d, s, r, f, e.rt, e.ls};
    endfunction

    task automatic expect_ev(input int c, input logic [2:0] st,
                             input logic [1:0] rt, input logic [7:0] ls);
        ev_t e;
        e.c  = c;
        e.st = st;
        e.rt = rt;
        e.ls = ls;
        q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: any change of the output tuple is one DUT response.
    initial begin
        logic [16:0] prev;
        logic [16:0] cur;
        ev_t         e;
        prev = RESET_TUPLE;
        forever begin
            @(negedge clk);
            cur = {state, dcm_rst, sys_rst, ready, fault, retry, loss};
            if (mon_on && (cur !== prev)) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if ((cur !== model(e)) || (cyc != e.c)) begin
                        n_bad++;
                        $display("FAIL event cyc=%0d got=%h required cyc=%0d val=%h",
                                 cyc, cur, e.c, model(e));
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int  t0, e0, e2, d0, f0;
        ev_t lo;

        repeat (3) @(negedge clk);
        n_vec++;
        if ({state, dcm_rst, sys_rst, ready, fault, retry, loss} !== RESET_TUPLE) begin
            n_bad++;
            $display("FAIL reset_state got=%h required=%h",
                     {state, dcm_rst, sys_rst, ready, fault, retry, loss}, RESET_TUPLE);
        end
        mon_on = 1'b1;

        // 1: normal bring-up, lock 20 cycles after reset release
        t0 = cyc;
        expect_ev(t0 + 4, S_WAIT, 2'd0, 8'd0);
        rst = 1'b0;
        wait_until(t0 + 20);
        e0 = cyc;
        locked = 1'b1;
        expect_ev(e0 + 3,  S_SET, 2'd0, 8'd0);
        expect_ev(e0 + 19, S_RUN, 2'd0, 8'd0);
        wait_until(e0 + 25);

        // 4: lock loss in RUN, then full re-sequence
        e0 = cyc;
        locked = 1'b0;
        expect_ev(e0 + 3, S_RST,  2'd0, 8'd1);
        expect_ev(e0 + 7, S_WAIT, 2'd0, 8'd1);
        wait_until(e0 + 10);
        e2 = cyc;
        locked = 1'b1;
        expect_ev(e2 + 3,  S_SET, 2'd0, 8'd1);
        expect_ev(e2 + 19, S_RUN, 2'd0, 8'd1);
        wait_until(e2 + 25);

        // 5a: resync request alone, loss count unchanged
        e0 = cyc;
        resync = 1'b1;
        expect_ev(e0 + 1,  S_RST,  2'd0, 8'd1);
        expect_ev(e0 + 5,  S_WAIT, 2'd0, 8'd1);
        expect_ev(e0 + 6,  S_SET,  2'd0, 8'd1);
        expect_ev(e0 + 22, S_RUN,  2'd0, 8'd1);
        @(negedge clk);
        resync = 1'b0;
        wait_until(e0 + 28);

        // 5b: resync coincident with lock drop counts as a loss;
        //     5c: resync while in WAIT_LOCK has no effect
        e0 = cyc;
        locked = 1'b0;
        expect_ev(e0 + 3, S_RST,  2'd0, 8'd2);
        expect_ev(e0 + 7, S_WAIT, 2'd0, 8'd2);
        wait_until(e0 + 2);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_until(e0 + 8);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_until(e0 + 10);
        e2 = cyc;
        locked = 1'b1;
        expect_ev(e2 + 3, S_SET, 2'd0, 8'd2);

        // 3: 3-cycle lock drop at settle count 10 forces a full new settle
        d0 = e2 + 11;
        wait_until(d0);
        locked = 1'b0;
        expect_ev(d0 + 3, S_WAIT, 2'd0, 8'd2);
        wait_until(d0 + 3);
        locked = 1'b1;
        expect_ev(d0 + 6,  S_SET, 2'd0, 8'd2);
        expect_ev(d0 + 22, S_RUN, 2'd0, 8'd2);
        wait_until(d0 + 28);

        // 6a: RST during SETTLE
        e0 = cyc;
        resync = 1'b1;
        expect_ev(e0 + 1, S_RST,  2'd0, 8'd2);
        expect_ev(e0 + 5, S_WAIT, 2'd0, 8'd2);
        expect_ev(e0 + 6, S_SET,  2'd0, 8'd2);
        @(negedge clk);
        resync = 1'b0;
        wait_until(e0 + 8);
        rst = 1'b1;
        locked = 1'b0;
        expect_ev(e0 + 9, S_RST, 2'd0, 8'd0);
        wait_until(e0 + 11);

        // 2: no lock at all -> three timed-out attempts then FAULT
        t0 = cyc;
        rst = 1'b0;
        expect_ev(t0 + 4,   S_WAIT, 2'd0, 8'd0);
        expect_ev(t0 + 104, S_RST,  2'd1, 8'd0);
        expect_ev(t0 + 108, S_WAIT, 2'd1, 8'd0);
        expect_ev(t0 + 208, S_RST,  2'd2, 8'd0);
        expect_ev(t0 + 212, S_WAIT, 2'd2, 8'd0);
        expect_ev(t0 + 312, S_FLT,  2'd2, 8'd0);
        wait_until(t0 + 320);
        locked = 1'b1;
        wait_until(t0 + 325);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_until(t0 + 340);

        // 6b: RST during FAULT, then bring-up with lock already present
        f0 = cyc;
        rst = 1'b1;
        expect_ev(f0 + 1, S_RST, 2'd0, 8'd0);
        wait_until(f0 + 3);
        t0 = cyc;
        rst = 1'b0;
        expect_ev(t0 + 4,  S_WAIT, 2'd0, 8'd0);
        expect_ev(t0 + 5,  S_SET,  2'd0, 8'd0);
        expect_ev(t0 + 21, S_RUN,  2'd0, 8'd0);
        wait_until(t0 + 25);

        // Lock arriving on the timeout cycle wins over the timeout
        f0 = cyc;
        rst = 1'b1;
        locked = 1'b0;
        expect_ev(f0 + 1, S_RST, 2'd0, 8'd0);
        wait_until(f0 + 3);
        t0 = cyc;
        rst = 1'b0;
        expect_ev(t0 + 4, S_WAIT, 2'd0, 8'd0);
        wait_until(t0 + 101);
        locked = 1'b1;
        expect_ev(t0 + 104, S_SET, 2'd0, 8'd0);
        expect_ev(t0 + 120, S_RUN, 2'd0, 8'd0);
        wait_until(t0 + 126);

        while (q.size() != 0) begin
            lo = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missing_event got=none required cyc=%0d val=%h", lo.c, model(lo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
